// File: rtl/coffee_order_controller.sv
// Coffee purchase sequencer: accumulates coins, drives the external price
// comparator, commands the dispenser and pays out change or a full refund.
module coffee_order_controller #(
  parameter int unsigned  N       = 8,
  parameter logic [N-1:0] PRICE0  = N'(10),
  parameter logic [N-1:0] PRICE1  = N'(15),
  parameter logic [N-1:0] PRICE2  = N'(20),
  parameter logic [N-1:0] PRICE3  = N'(25),
  parameter logic [15:0]  TIMEOUT = 16'd1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         coin_valid,
  input  logic [N-1:0] coin_value,
  input  logic         select_valid,
  input  logic [1:0]   drink_sel,
  input  logic         cancel,
  output logic         cmp_enable,
  output logic [N-1:0] cmp_total,
  output logic [N-1:0] cmp_price,
  input  logic         cmp_ok,
  input  logic [N-1:0] cmp_change,
  output logic         dispense_start,
  output logic [1:0]   dispense_drink,
  input  logic         dispense_done,
  output logic         change_valid,
  output logic [N-1:0] change_amount,
  output logic [N-1:0] total,
  output logic         busy,
  output logic         insufficient
);

  localparam int unsigned TW = 16;
  // Timer fires on the cycle it would reach TIMEOUT-1.
  localparam logic [TW-1:0] TIMER_LAST = TIMEOUT - 16'd2;

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DISPENSE, PAYOUT} state_t;

  state_t         state, next_state;
  logic [TW-1:0]  timer, next_timer;
  logic [N-1:0]   next_total, next_cmp_total, next_cmp_price, next_change;
  logic [1:0]     next_drink;
  logic           next_dispense_start, next_change_valid, next_insufficient;
  logic           next_cmp_enable, next_busy;
  logic [N:0]     coin_sum;
  logic [N-1:0]   credit;

  function automatic logic [N-1:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return PRICE0;
      2'd1:    return PRICE1;
      2'd2:    return PRICE2;
      default: return PRICE3;
    endcase
  endfunction

  always_comb begin
    next_state          = state;
    next_timer          = timer;
    next_total          = total;
    next_cmp_total      = cmp_total;
    next_cmp_price      = cmp_price;
    next_change         = change_amount;
    next_drink          = dispense_drink;
    next_dispense_start = 1'b0;
    next_insufficient   = 1'b0;

    // Credit including a coin arriving this cycle, saturating at all-ones.
    coin_sum = {1'b0, total} + {1'b0, coin_value};
    credit   = total;
    if (coin_valid) credit = coin_sum[N] ? {N{1'b1}} : coin_sum[N-1:0];

    case (state)
      IDLE: begin
        if (coin_valid) begin
          next_total = credit;
          next_timer = '0;
          next_state = COLLECT;
        end else if (select_valid && total == '0) begin
          next_insufficient = 1'b1;
        end
      end
      COLLECT: begin
        next_total = credit;
        if (cancel) begin
          next_change = credit;
          next_state  = PAYOUT;
        end else if (select_valid) begin
          next_drink     = drink_sel;
          next_cmp_price = price_of(drink_sel);
          next_cmp_total = credit;
          next_state     = CHECK;
        end else if (coin_valid) begin
          next_timer = '0;
        end else if (timer == TIMER_LAST) begin
          next_change = total;
          next_state  = PAYOUT;
        end else begin
          next_timer = timer + TW'(1);
        end
      end
      CHECK: begin
        if (cmp_ok) begin
          next_change         = cmp_change;
          next_dispense_start = 1'b1;
          next_state          = DISPENSE;
        end else begin
          next_insufficient = 1'b1;
          next_timer        = '0;
          next_state        = COLLECT;
        end
      end
      DISPENSE: begin
        if (dispense_done) next_state = PAYOUT;
      end
      PAYOUT: begin
        next_total = '0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    next_cmp_enable   = (next_state == CHECK);
    next_change_valid = (next_state == PAYOUT);
    next_busy         = (next_state == CHECK) || (next_state == DISPENSE) ||
                        (next_state == PAYOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      total          <= '0;
      cmp_total      <= '0;
      cmp_price      <= '0;
      change_amount  <= '0;
      dispense_drink <= '0;
      dispense_start <= 1'b0;
      change_valid   <= 1'b0;
      insufficient   <= 1'b0;
      cmp_enable     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= next_state;
      timer          <= next_timer;
      total          <= next_total;
      cmp_total      <= next_cmp_total;
      cmp_price      <= next_cmp_price;
      change_amount  <= next_change;
      dispense_drink <= next_drink;
      dispense_start <= next_dispense_start;
      change_valid   <= next_change_valid;
      insufficient   <= next_insufficient;
      cmp_enable     <= next_cmp_enable;
      busy           <= next_busy;
    end
  end

endmodule

// File: tb/tb_coffee_order_controller.sv
// Bench for coffee_order_controller: directed purchases plus randomized
// orders checked against a credit/price model of the vending rules.
module tb_coffee_order_controller;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         coin_valid, select_valid, cancel, dispense_done;
  logic [N-1:0] coin_value;
  logic [1:0]   drink_sel;
  logic         cmp_enable, cmp_ok, dispense_start, change_valid, busy, insufficient;
  logic [N-1:0] cmp_total, cmp_price, cmp_change, change_amount, total;
  logic [1:0]   dispense_drink;

  int tests = 0;
  int fails = 0;
  int credit = 0;
  int pending = 0;
  int n_disp = 0, n_chg = 0, exp_disp = 0, exp_chg = 0;
  int prices[4] = '{10, 15, 20, 25};

  always #5 clk = ~clk;

  // External comparator behaviour
  assign cmp_ok     = cmp_enable && (cmp_total >= cmp_price);
  assign cmp_change = cmp_total - cmp_price;

  coffee_order_controller #(.N(N), .TIMEOUT(16'd16)) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .select_valid(select_valid), .drink_sel(drink_sel), .cancel(cancel),
    .cmp_enable(cmp_enable), .cmp_total(cmp_total), .cmp_price(cmp_price),
    .cmp_ok(cmp_ok), .cmp_change(cmp_change),
    .dispense_start(dispense_start), .dispense_drink(dispense_drink),
    .dispense_done(dispense_done),
    .change_valid(change_valid), .change_amount(change_amount),
    .total(total), .busy(busy), .insufficient(insufficient)
  );

  always @(negedge clk) begin
    if (dispense_start === 1'b1) n_disp++;
    if (change_valid === 1'b1) n_chg++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int add_sat(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic reset_zero(input string tag);
    chk({tag, "_total"}, total, 0);
    chk({tag, "_cmp_total"}, cmp_total, 0);
    chk({tag, "_cmp_price"}, cmp_price, 0);
    chk({tag, "_change_amount"}, change_amount, 0);
    chk({tag, "_pulses"}, {dispense_start, change_valid, insufficient, cmp_enable, busy}, 0);
  endtask

  task automatic insert(input int v);
    coin_valid = 1'b1;
    coin_value = 8'(v);
    tick();
    coin_valid = 1'b0;
    credit = add_sat(credit, v);
    chk("total_after_coin", total, credit);
  endtask

  task automatic payout(input int amt);
    exp_chg++;
    chk("change_valid", change_valid, 1);
    chk("change_amount", change_amount, amt);
    tick();
    credit = 0;
    chk("change_pulse_end", change_valid, 0);
    chk("total_cleared", total, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic choose(input int d, input int extra, output bit ok);
    select_valid = 1'b1;
    drink_sel = 2'(d);
    if (extra > 0) begin
      coin_valid = 1'b1;
      coin_value = 8'(extra);
      credit = add_sat(credit, extra);
    end
    tick();
    select_valid = 1'b0;
    coin_valid = 1'b0;
    chk("check_enable", cmp_enable, 1);
    chk("check_busy", busy, 1);
    chk("check_cmp_total", cmp_total, credit);
    chk("check_cmp_price", cmp_price, prices[d]);
    chk("early_dispense", dispense_start, 0);
    tick();
    chk("cmp_enable_drop", cmp_enable, 0);
    ok = (credit >= prices[d]);
    if (ok) begin
      exp_disp++;
      pending = credit - prices[d];
      chk("dispense_start", dispense_start, 1);
      chk("dispense_drink", dispense_drink, d);
      chk("no_insufficient", insufficient, 0);
    end else begin
      chk("insufficient", insufficient, 1);
      chk("no_dispense", dispense_start, 0);
      chk("credit_kept", total, credit);
      chk("busy_after_reject", busy, 0);
    end
  endtask

  task automatic brew(input int waits);
    for (int i = 0; i < waits; i++) begin
      coin_valid   = 1'($urandom_range(0, 1));
      coin_value   = 8'($urandom_range(1, 50));
      select_valid = 1'($urandom_range(0, 1));
      cancel       = 1'($urandom_range(0, 1));
      tick();
      chk("dispense_busy", busy, 1);
      chk("dispense_no_change", change_valid, 0);
      chk("dispense_total_frozen", total, credit);
    end
    coin_valid = 1'b0;
    select_valid = 1'b0;
    cancel = 1'b0;
    dispense_done = 1'b1;
    tick();
    dispense_done = 1'b0;
    payout(pending);
  endtask

  task automatic cancel_now(input int extra);
    cancel = 1'b1;
    if (extra > 0) begin
      coin_valid = 1'b1;
      coin_value = 8'(extra);
      credit = add_sat(credit, extra);
    end
    tick();
    cancel = 1'b0;
    coin_valid = 1'b0;
    payout(credit);
  endtask

  initial begin
    bit ok;
    int cyc;
    rst = 1'b1;
    coin_valid = 1'b0; coin_value = '0; select_valid = 1'b0; drink_sel = '0;
    cancel = 1'b0; dispense_done = 1'b0;
    tick();
    tick();
    reset_zero("reset");
    rst = 1'b0;

    // Select with no credit, then cancel in IDLE
    select_valid = 1'b1; drink_sel = 2'd2;
    tick();
    select_valid = 1'b0;
    chk("idle_insufficient", insufficient, 1);
    chk("idle_no_check", cmp_enable, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("idle_insufficient_end", insufficient, 0);
    chk("idle_cancel_ignored", change_valid, 0);

    // Exact payment
    insert(5); insert(5);
    choose(0, 0, ok);
    brew(2);

    // Overpayment
    insert(20); insert(10);
    choose(1, 0, ok);
    brew(1);

    // Insufficient then top-up
    insert(10);
    choose(3, 0, ok);
    insert(20);
    choose(3, 0, ok);
    brew(0);

    // Cancel with a coincident coin
    insert(7); insert(3);
    cancel_now(2);
    chk("cancel_no_dispense", n_disp, exp_disp);

    // Inactivity timeout
    insert(9);
    cyc = 1;
    while (change_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("timeout_cycles", cyc, 16);
    payout(9);

    // Saturation, then reset while dispensing
    insert(200); insert(100);
    choose(3, 0, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    credit = 0;
    reset_zero("mid_reset");
    dispense_done = 1'b1;
    tick();
    dispense_done = 1'b0;
    tick();
    tick();
    chk("no_change_after_reset", n_chg, exp_chg);
    chk("idle_after_reset", busy, 0);

    // Randomized orders
    for (int t = 0; t < 14; t++) begin
      int d, extra, nc;
      nc = $urandom_range(1, 3);
      for (int c = 0; c < nc; c++) insert($urandom_range(1, 120));
      d = $urandom_range(0, 3);
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      if ($urandom_range(0, 4) == 0) begin
        cancel_now(extra);
      end else begin
        choose(d, extra, ok);
        if (ok) begin
          brew($urandom_range(0, 3));
        end else if ($urandom_range(0, 1) == 1) begin
          cancel_now(0);
        end else begin
          insert(prices[d]);
          choose(d, 0, ok);
          brew($urandom_range(0, 3));
        end
      end
    end

    tick();
    chk("dispense_count", n_disp, exp_disp);
    chk("change_count", n_chg, exp_chg);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
